spm_ctrl_gen: RTL
=================

# spm_ctrl_gen

Parametrised self-programming (SPM) controller for the AVR core: owns SPMCSR, arms a programmable issue window after a valid CSR write, launches one of six flash/fuse operations when the core executes SPM, and supervises completion with an optional timeout. It also steers LPM reads to the signature row or the lock/fuse bits. It sits between the core's I/O or data-memory bus, the core's SPM/LPM decode, and the flash programming engine.

## Interface
- USE_DM_LOC, 0: 0 decodes SPMCSR on the I/O bus (adr/iore/iowe); 1 decodes it on the DM bus (ramadr/ramre/ramwe/dm_sel).
- CSR_ADR, 8'h57: SPMCSR address; bits [5:0] are compared when USE_DM_LOC=0, all 8 bits when USE_DM_LOC=1.
- WAIT_CYC, 4: issue-window length in cycles (2..16).
- TMO_CYC, 0: completion timeout in cycles (0 = disabled, otherwise 1..65535).
- ireset  in  1  asynchronous active-low reset
- cp2  in  1  clock (single clock domain, rising edge)
- adr/iore/iowe  in  6/1/1  I/O bus address and strobes
- dbus_in / dbus_out  in/out  8  I/O data
- io_out_en  out  1  I/O read-select: iore & sel & !USE_DM_LOC
- ramadr/ramre/ramwe/dm_sel  in  8/1/1/1  DM bus address, strobes and select
- dm_dbus_in / dm_dbus_out  in/out  8  DM data
- dm_out_en  out  1  DM read-select: dm_sel & ramre & sel & USE_DM_LOC
- spm_inst  in  1  core is executing SPM this cycle
- lpm_inst  in  1  core is executing LPM this cycle
- spm_wait  out  1  core stall request
- op_vld  out  6  one-hot op strobe {sigrd, rwwsre, blbset, pgwrt, pgers, spmen}
- op_rdy  in  1  programming engine has finished the current op
- rww_busy  in  1  RWW section busy; read back as RWWSB
- lpm_sig_sel / lpm_fuse_sel  out  1  steer the current LPM to the signature row or to lock/fuse bits
- spm_err  out  1  sticky timeout flag
- spm_irq  out  1  interrupt request; spm_irq_ack  in  1  acknowledge

## Operation
- SPMCSR bits: 7 SPMIE (R/W), 6 RWWSB (read-only, equals rww_busy), 5..0 op field {SIGRD, RWWSRE, BLBSET, PGWRT, PGERS, SPMEN}. Read value is {SPMIE, rww_busy, op_buf}. The unused data output is driven 0.
- Valid op codes: 100001, 010001, 001001, 000101, 000011, 000001.
- Every CSR write updates SPMIE. The op field is captured only in IDLE and only when the code is valid. Otherwise the write is ignored.
- States: IDLE, ARM, EXEC.
  - IDLE -> ARM: valid CSR write. op_buf <= op code, window counter <= 0, spm_err <= 0, irq flag <= 0.
  - ARM -> EXEC: spm_inst=1. Not taken when op is SIGRD; SIGRD returns to IDLE with no op strobe.
  - ARM -> IDLE: lpm_inst=1 while op is SIGRD or BLBSET (the read consumes the op), or the window counter reaches WAIT_CYC-1 with no instruction. op_buf <= 0; no IRQ.
  - EXEC -> IDLE: op_rdy=1, or TMO_CYC≠0 and the timeout counter reaches TMO_CYC-1. On timeout, spm_err <= 1. op_buf <= 0 and irq flag <= 1 in both cases.
- lpm_sig_sel = ARM & op==SIGRD. lpm_fuse_sel = ARM & op==BLBSET. Both are combinational.
- op_vld: registered decode of the next state. The bit for op_buf is high in every EXEC cycle, and all bits are 0 otherwise.
- spm_irq = irq flag & SPMIE. The flag is cleared by spm_irq_ack or by a new arm. If a set and a clear occur in the same cycle, the set wins.
- A CSR write during ARM or EXEC changes SPMIE only.

## Timing
- Reset values: state IDLE, op_buf 0, SPMIE 0, all outputs 0.
- CSR write at edge n → ARM from n+1. spm_inst is accepted in any of the WAIT_CYC ARM cycles.
- spm_inst sampled at edge k → op_vld and spm_wait high from k+1.
- op_rdy sampled at edge m → op_vld and spm_wait low from m+1, state IDLE from m+1, irq flag high from m+1.
- A timeout behaves identically to op_rdy, and spm_err rises at the same edge.
- Reset asserted in ARM or EXEC aborts immediately. op_vld drops asynchronously and no IRQ is raised.

## Structure
- Shared package holds: op codes, SPMCSR bit indices, the state encoding, and the op_vld bit order.
- One natural sub-module, spm_cyc_cnt: a 16-bit up-counter with clear and terminal-compare. It is shared between the window and timeout functions, which are never active together.

## Test plan
- Write 0x01, spm_inst in the 2nd ARM cycle, op_rdy 5 cycles later → op_vld=000001 for 5 cycles; spm_wait matches; flag set; spm_irq=0 because SPMIE=0.
- Write 0x85, spm_inst, op_rdy, no ack → CSR reads 0x85 during EXEC, 0x80 afterwards; spm_irq=1 until spm_irq_ack.
- Write 0x03 with no spm_inst and WAIT_CYC=4 → IDLE after exactly 4 ARM cycles; op_vld never set; CSR reads 0x00.
- TMO_CYC=8, write 0x05, spm_inst, op_rdy held low → IDLE after 8 EXEC cycles; spm_err=1; spm_err cleared by the next valid write.
- Write 0x21, then lpm_inst → lpm_sig_sel=1 during ARM; IDLE on the next edge; op_vld=0. Write 0x1F (invalid) → op ignored, SPMIE updated; rww_busy=1 reads back as bit 6.
- Run the above with both USE_DM_LOC=0 and USE_DM_LOC=1. Reset mid-EXEC → all outputs 0 immediately.

Source files
------------

// File: rtl/spm_ctrl_gen_pkg.sv
// Shared definitions for the SPM controller: op codes, SPMCSR layout,
// controller states and the op_vld strobe bit order.
package spm_ctrl_gen_pkg;

    localparam int OP_W  = 6;
    localparam int CNT_W = 16;

    // SPMCSR op-field codes (bit 0 is always SPMEN)
    localparam logic [OP_W-1:0] OP_SIGRD  = 6'b100001;
    localparam logic [OP_W-1:0] OP_RWWSRE = 6'b010001;
    localparam logic [OP_W-1:0] OP_BLBSET = 6'b001001;
    localparam logic [OP_W-1:0] OP_PGWRT  = 6'b000101;
    localparam logic [OP_W-1:0] OP_PGERS  = 6'b000011;
    localparam logic [OP_W-1:0] OP_SPMEN  = 6'b000001;

    // SPMCSR bit positions
    localparam int CSR_SPMIE = 7;
    localparam int CSR_RWWSB = 6;

    // op_vld strobe bit order {sigrd, rwwsre, blbset, pgwrt, pgers, spmen}
    localparam int VLD_SPMEN  = 0;
    localparam int VLD_PGERS  = 1;
    localparam int VLD_PGWRT  = 2;
    localparam int VLD_BLBSET = 3;
    localparam int VLD_RWWSRE = 4;
    localparam int VLD_SIGRD  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_EXEC = 2'd2
    } spmState_e;

    function automatic logic opValid(input logic [OP_W-1:0] op);
        logic ok;
        case (op)
            OP_SIGRD, OP_RWWSRE, OP_BLBSET,
            OP_PGWRT, OP_PGERS, OP_SPMEN: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Map an op code onto its single op_vld strobe bit.
    function automatic logic [OP_W-1:0] opStrobe(input logic [OP_W-1:0] op);
        logic [OP_W-1:0] s;
        s = '0;
        case (op)
            OP_SIGRD:  s[VLD_SIGRD]  = 1'b1;
            OP_RWWSRE: s[VLD_RWWSRE] = 1'b1;
            OP_BLBSET: s[VLD_BLBSET] = 1'b1;
            OP_PGWRT:  s[VLD_PGWRT]  = 1'b1;
            OP_PGERS:  s[VLD_PGERS]  = 1'b1;
            OP_SPMEN:  s[VLD_SPMEN]  = 1'b1;
            default:   s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/spm_ctrl_gen_if.sv
// Bus bundle between the core / programming engine and the SPM controller.
interface spm_ctrl_gen_if;
    import spm_ctrl_gen_pkg::*;

    logic [5:0]      adr;
    logic            iore;
    logic            iowe;
    logic [7:0]      dbus_in;
    logic [7:0]      dbus_out;
    logic            io_out_en;
    logic [7:0]      ramadr;
    logic            ramre;
    logic            ramwe;
    logic            dm_sel;
    logic [7:0]      dm_dbus_in;
    logic [7:0]      dm_dbus_out;
    logic            dm_out_en;
    logic            spm_inst;
    logic            lpm_inst;
    logic            spm_wait;
    logic [OP_W-1:0] op_vld;
    logic            op_rdy;
    logic            rww_busy;
    logic            lpm_sig_sel;
    logic            lpm_fuse_sel;
    logic            spm_err;
    logic            spm_irq;
    logic            spm_irq_ack;

    modport master (
        output adr, iore, iowe, dbus_in, ramadr, ramre, ramwe, dm_sel, dm_dbus_in,
               spm_inst, lpm_inst, op_rdy, rww_busy, spm_irq_ack,
        input  dbus_out, io_out_en, dm_dbus_out, dm_out_en, spm_wait, op_vld,
               lpm_sig_sel, lpm_fuse_sel, spm_err, spm_irq
    );

    modport slave (
        input  adr, iore, iowe, dbus_in, ramadr, ramre, ramwe, dm_sel, dm_dbus_in,
               spm_inst, lpm_inst, op_rdy, rww_busy, spm_irq_ack,
        output dbus_out, io_out_en, dm_dbus_out, dm_out_en, spm_wait, op_vld,
               lpm_sig_sel, lpm_fuse_sel, spm_err, spm_irq
    );

endinterface

// File: rtl/spm_ctrl_gen_cyc_cnt.sv
// Cycle counter shared by the issue window and the completion timeout.
module spm_cyc_cnt
    import spm_ctrl_gen_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count up while enabled; a clear always restarts from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/spm_ctrl_gen.sv
// SPM controller: owns SPMCSR, arms an issue window after a valid write,
// launches the flash op on SPM and supervises completion / timeout.
module spm_ctrl_gen
    import spm_ctrl_gen_pkg::*;
#(
    parameter int         USE_DM_LOC = 0,
    parameter logic [7:0] CSR_ADR    = 8'h57,
    parameter int         WAIT_CYC   = 4,
    parameter int         TMO_CYC    = 0
) (
    input logic           cp2,
    input logic           ireset,
    spm_ctrl_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] WIN_TERM = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_TERM = CNT_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);
    localparam bit               TMO_EN   = (TMO_CYC != 0);

    spmState_e        state_q, state_d;
    logic [OP_W-1:0]  opBuf_q, opBuf_d;
    logic [OP_W-1:0]  opVld_q;
    logic             spmie_q, err_q, irqFlag_q;
    logic             csrSel, csrWr;
    logic [7:0]       csrWrData, csrRdData;
    logic             armStart, doneSet, tmoSet;
    logic             cntClr, cntHit;
    logic [CNT_W-1:0] cntTerm;

    // Decode SPMCSR accesses on whichever bus this instance is attached to.
    always_comb begin
        if (USE_DM_LOC != 0) begin
            csrSel    = (bus.ramadr == CSR_ADR);
            csrWr     = bus.dm_sel && bus.ramwe && csrSel;
            csrWrData = bus.dm_dbus_in;
        end else begin
            csrSel    = (bus.adr == CSR_ADR[5:0]);
            csrWr     = bus.iowe && csrSel;
            csrWrData = bus.dbus_in;
        end
    end

    // Next-state logic for the IDLE / ARM / EXEC controller and its op buffer.
    always_comb begin
        state_d  = state_q;
        opBuf_d  = opBuf_q;
        armStart = 1'b0;
        doneSet  = 1'b0;
        tmoSet   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (csrWr && opValid(csrWrData[OP_W-1:0])) begin
                    state_d  = ST_ARM;
                    opBuf_d  = csrWrData[OP_W-1:0];
                    armStart = 1'b1;
                end
            end
            ST_ARM: begin
                if (bus.spm_inst) begin
                    if (opBuf_q == OP_SIGRD) begin
                        state_d = ST_IDLE;
                        opBuf_d = '0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else if (bus.lpm_inst && (opBuf_q == OP_SIGRD || opBuf_q == OP_BLBSET)) begin
                    state_d = ST_IDLE;
                    opBuf_d = '0;
                end else if (cntHit) begin
                    state_d = ST_IDLE;
                    opBuf_d = '0;
                end
            end
            ST_EXEC: begin
                if (bus.op_rdy) begin
                    state_d = ST_IDLE;
                    opBuf_d = '0;
                    doneSet = 1'b1;
                end else if (TMO_EN && cntHit) begin
                    state_d = ST_IDLE;
                    opBuf_d = '0;
                    doneSet = 1'b1;
                    tmoSet  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                opBuf_d = '0;
            end
        endcase
    end

    // Controller state, op buffer and the op strobe decoded from the next state.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state_q <= ST_IDLE;
            opBuf_q <= '0;
            opVld_q <= '0;
        end else begin
            state_q <= state_d;
            opBuf_q <= opBuf_d;
            opVld_q <= (state_d == ST_EXEC) ? opStrobe(opBuf_d) : '0;
        end
    end

    // SPMIE, sticky timeout flag and interrupt flag (a set beats a clear).
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            spmie_q   <= 1'b0;
            err_q     <= 1'b0;
            irqFlag_q <= 1'b0;
        end else begin
            if (csrWr) begin
                spmie_q <= csrWrData[CSR_SPMIE];
            end
            if (tmoSet) begin
                err_q <= 1'b1;
            end else if (armStart) begin
                err_q <= 1'b0;
            end
            if (doneSet) begin
                irqFlag_q <= 1'b1;
            end else if (armStart || bus.spm_irq_ack) begin
                irqFlag_q <= 1'b0;
            end
        end
    end

    // One counter serves both the issue window (ARM) and the timeout (EXEC).
    assign cntClr  = (state_d != state_q);
    assign cntTerm = (state_q == ST_ARM) ? WIN_TERM : TMO_TERM;

    spm_cyc_cnt uCycCnt (
        .clk_i  (cp2),
        .rst_ni (ireset),
        .clr_i  (cntClr),
        .en_i   (state_q != ST_IDLE),
        .term_i (cntTerm),
        .hit_o  (cntHit)
    );

    assign csrRdData        = {spmie_q, bus.rww_busy, opBuf_q};
    assign bus.dbus_out     = (USE_DM_LOC != 0) ? 8'h00 : csrRdData;
    assign bus.dm_dbus_out  = (USE_DM_LOC != 0) ? csrRdData : 8'h00;
    assign bus.io_out_en    = (USE_DM_LOC == 0) && bus.iore && csrSel;
    assign bus.dm_out_en    = (USE_DM_LOC != 0) && bus.dm_sel && bus.ramre && csrSel;
    assign bus.spm_wait     = (state_q == ST_EXEC);
    assign bus.op_vld       = opVld_q;
    assign bus.lpm_sig_sel  = (state_q == ST_ARM) && (opBuf_q == OP_SIGRD);
    assign bus.lpm_fuse_sel = (state_q == ST_ARM) && (opBuf_q == OP_BLBSET);
    assign bus.spm_err      = err_q;
    assign bus.spm_irq      = irqFlag_q && spmie_q;

endmodule
